// File: rtl/can_frame_field_decoder.sv
// can_frame_field_decoder: destuffs a sampled CAN bit stream and labels each destuffed bit with its frame-field code
module can_frame_field_decoder (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Data,
  input  logic       i_bit_valid,
  output logic       o_Data,
  output logic [0:4] o_frame_field,
  output logic       o_bit_valid,
  output logic       o_stuff_error,
  output logic       o_ide,
  output logic       o_rtr,
  output logic [3:0] o_dlc,
  output logic       o_frame_done
);
  typedef enum logic [4:0] {
    F_IDLE = 5'd0, F_SOF = 5'd1, F_BASE = 5'd2, F_RTR = 5'd3, F_IDE = 5'd4, F_EOF = 5'd5,
    F_R0 = 5'd6, F_DLC = 5'd7, F_SRR = 5'd8, F_EXT = 5'd9, F_R1 = 5'd11, F_DATA = 5'd12,
    F_CRC = 5'd13, F_INT = 5'd15, F_ACK = 5'd16, F_CD = 5'd17, F_AD = 5'd18, F_ERR = 5'd19
  } field_e;
  field_e st_q, st_d, pend_code_q, pend_code_d, ff_q, ff_d, lbl;
  logic [6:0] cnt_q, cnt_d, nbits;
  logic [2:0] run_q, run_d, dsh_q, dsh_d;
  logic [3:0] dlc_q, dlc_d;
  logic last_q, last_d, pend_v_q, pend_v_d, pend_bit_q, pend_bit_d, pend_done_q, pend_done_d;
  logic data_q, data_d, bv_q, bv_d, se_q, se_d, ide_q, ide_d, rtr_q, rtr_d, done_q, done_d, stuffing;
  assign o_Data        = data_q;
  assign o_frame_field = ff_q;
  assign o_bit_valid   = bv_q;
  assign o_stuff_error = se_q;
  assign o_ide         = ide_q;
  assign o_rtr         = rtr_q;
  assign o_dlc         = dlc_q;
  assign o_frame_done  = done_q;
  // Per strobe: track runs, drop stuff bits, emit the held bit and classify the new one
  always_comb begin
    st_d = st_q; cnt_d = cnt_q; run_d = run_q; dsh_d = dsh_q; dlc_d = dlc_q; last_d = last_q;
    pend_v_d = pend_v_q; pend_bit_d = pend_bit_q; pend_code_d = pend_code_q; pend_done_d = pend_done_q;
    data_d = data_q; ff_d = ff_q; ide_d = ide_q; rtr_d = rtr_q;
    bv_d = 1'b0; se_d = 1'b0; done_d = 1'b0; lbl = st_q;
    nbits = {(dlc_q[3] ? 4'd8 : dlc_q), 3'b000};
    stuffing = st_q inside {F_BASE, F_RTR, F_IDE, F_EXT, F_R1, F_R0, F_DLC, F_DATA, F_CRC, F_CD};
    if (i_bit_valid) begin
      last_d = i_Data;
      run_d = (i_Data != last_q) ? 3'd1 : (run_q == 3'd7 ? run_q : run_q + 3'd1);
      if (st_q == F_ERR) begin
        data_d = i_Data; ff_d = F_ERR; bv_d = 1'b1;
        cnt_d = i_Data ? cnt_q + 7'd1 : 7'd0;
        if (i_Data && cnt_q == 7'd10) begin
          st_d = F_IDLE; cnt_d = 7'd0;
        end
      end else if (stuffing && run_q == 3'd5) begin
        if (i_Data == last_q) begin
          se_d = 1'b1; st_d = F_ERR; cnt_d = {6'd0, i_Data};
          data_d = i_Data; ff_d = F_ERR; bv_d = 1'b1; pend_v_d = 1'b0;
        end
      end else begin
        if (pend_v_q) begin
          data_d = pend_bit_q; bv_d = 1'b1; done_d = pend_done_q;
          ff_d = (pend_code_q == F_RTR && st_q == F_IDE && i_Data) ? F_SRR : pend_code_q;
        end
        pend_v_d = 1'b1; pend_bit_d = i_Data; pend_done_d = 1'b0; cnt_d = cnt_q + 7'd1;
        case (st_q)
          F_IDLE: begin
            lbl = i_Data ? F_IDLE : F_SOF; cnt_d = 7'd0;
            if (!i_Data) begin
              st_d = F_BASE; ide_d = 1'b0; rtr_d = 1'b0; dlc_d = 4'd0;
            end
          end
          F_BASE: if (cnt_q == 7'd10) begin st_d = F_RTR; cnt_d = 7'd0; end
          F_RTR: begin
            st_d = ide_q ? F_R1 : F_IDE; cnt_d = 7'd0;
            if (ide_q) rtr_d = i_Data;
          end
          F_IDE: begin
            ide_d = i_Data; st_d = i_Data ? F_EXT : F_R0; cnt_d = 7'd0;
            if (!i_Data) rtr_d = pend_bit_q;
          end
          F_EXT: if (cnt_q == 7'd17) begin st_d = F_RTR; cnt_d = 7'd0; end
          F_R1: begin st_d = F_R0; cnt_d = 7'd0; end
          F_R0: begin st_d = F_DLC; cnt_d = 7'd0; end
          F_DLC: begin
            dsh_d = {dsh_q[1:0], i_Data};
            if (cnt_q == 7'd3) begin
              dlc_d = {dsh_q, i_Data}; cnt_d = 7'd0;
              st_d = (rtr_q || {dsh_q, i_Data} == 4'd0) ? F_CRC : F_DATA;
            end
          end
          F_DATA: if (cnt_q == nbits - 7'd1) begin st_d = F_CRC; cnt_d = 7'd0; end
          F_CRC: if (cnt_q == 7'd14) begin st_d = F_CD; cnt_d = 7'd0; end
          F_CD: begin st_d = F_ACK; cnt_d = 7'd0; end
          F_ACK: begin st_d = F_AD; cnt_d = 7'd0; end
          F_AD: begin st_d = F_EOF; cnt_d = 7'd0; end
          F_EOF: begin
            pend_done_d = cnt_q == 7'd6;
            if (cnt_q == 7'd6) begin st_d = F_INT; cnt_d = 7'd0; end
          end
          F_INT: begin
            if (i_Data) begin
              if (cnt_q == 7'd2) begin st_d = F_IDLE; cnt_d = 7'd0; end
            end else if (cnt_q == 7'd2) begin
              lbl = F_SOF; st_d = F_BASE; cnt_d = 7'd0; ide_d = 1'b0; rtr_d = 1'b0; dlc_d = 4'd0;
            end else begin
              st_d = F_ERR; cnt_d = 7'd0; pend_v_d = 1'b0;
            end
          end
          default: ;
        endcase
        pend_code_d = lbl;
      end
    end
  end
  // State and output registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      st_q <= F_IDLE; cnt_q <= 7'd0; run_q <= 3'd0; dsh_q <= 3'd0; dlc_q <= 4'd0; last_q <= 1'b1;
      pend_v_q <= 1'b0; pend_bit_q <= 1'b1; pend_code_q <= F_IDLE; pend_done_q <= 1'b0;
      data_q <= 1'b1; ff_q <= F_IDLE; bv_q <= 1'b0; se_q <= 1'b0; ide_q <= 1'b0; rtr_q <= 1'b0; done_q <= 1'b0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; run_q <= run_d; dsh_q <= dsh_d; dlc_q <= dlc_d; last_q <= last_d;
      pend_v_q <= pend_v_d; pend_bit_q <= pend_bit_d; pend_code_q <= pend_code_d; pend_done_q <= pend_done_d;
      data_q <= data_d; ff_q <= ff_d; bv_q <= bv_d; se_q <= se_d; ide_q <= ide_d; rtr_q <= rtr_d; done_q <= done_d;
    end
  end
endmodule

// File: doc/can_frame_field_decoder.md
# can_frame_field_decoder

Bit-level CAN frame tracker that sits directly upstream of the form-error checker. It takes the sampled bus bit stream with a per-bit strobe, removes stuff bits, and detects stuff errors. It classifies every destuffed bit into a 5-bit frame-field code, then presents bit and code as a stable, aligned pair for the whole bit time, so the form, CRC and ACK checkers can sample them on any clock.

## Interface
- No parameters.
- `i_Clock` in 1 — system clock.
- `i_Reset` in 1 — asynchronous, active-high reset.
- `i_Data` in 1 — sampled bus bit, 1 = recessive.
- `i_bit_valid` in 1 — one-cycle strobe, one per bus bit.
- `o_Data` out 1 — destuffed bit, delayed one destuffed bit.
- `o_frame_field` out [0:4] — field code of `o_Data`.
- `o_bit_valid` out 1 — one-cycle pulse when `o_Data`/`o_frame_field` update.
- `o_stuff_error` out 1 — one-cycle pulse on stuff violation.
- `o_ide` out 1 — latched IDE of current frame.
- `o_rtr` out 1 — latched RTR of current frame.
- `o_dlc` out [3:0] — latched DLC.
- `o_frame_done` out 1 — one-cycle pulse when the 7th EOF bit is emitted.

## Operation
- Field codes:
  - 0 IDLE, 1 SOF, 2 ID_BASE, 3 RTR, 4 IDE, 5 EOF, 6 R0, 7 DLC, 8 SRR
  - 9 ID_EXT, 11 R1, 12 DATA, 13 CRC, 15 INTERMISSION, 16 ACK_SLOT
  - 17 CRC_DELIM, 18 ACK_DELIM, 19 ERROR
  - 10 and 14 are unused.
- Standard frame sequence, in bits:
  - SOF 1, ID_BASE 11, RTR 1, IDE 1 (=0), R0 1, DLC 4, DATA N, CRC 15
  - CRC_DELIM 1, ACK_SLOT 1, ACK_DELIM 1, EOF 7, INTERMISSION 3, then IDLE.
- Extended frame sequence, in bits:
  - SOF, ID_BASE 11, SRR 1, IDE 1 (=1), ID_EXT 18, RTR 1, R1 1, R0 1, DLC 4
  - then the same tail as the standard frame.
- The 12th arbitration bit is labelled RTR(3) when the following IDE bit is 0, and SRR(8) when it is 1. This is the reason for the one-bit output delay.
- Data length: N = 0 if RTR=1; otherwise N = 8·min(DLC,8). DLC 9–15 gives 64 bits.
- IDLE: recessive bits stay IDLE; a dominant bit starts SOF.
- INTERMISSION:
  - dominant on bit 3 is SOF of a new frame;
  - dominant on bit 1 or 2 goes to ERROR.
- Destuffing:
  - Active from SOF through the last CRC bit, inclusive. This covers a stuff bit that follows the last CRC bit.
  - The run counter counts consecutive equal bits, stuff bits included.
  - After 5 equal bits, the next strobed bit is a stuff bit. It is discarded: no label and no `o_bit_valid`. Its value starts a new run of length 1.
  - A stuff bit equal to the previous bit is a stuff error.
- Stuff error:
  - `o_stuff_error` pulses.
  - The next clock forces `o_frame_field`=19 with `o_Data`=`i_Data`; the pending delayed bit is dropped.
  - ERROR holds until 11 consecutive recessive bits are received, then IDLE.
  - ERROR bits are not delayed and pulse `o_bit_valid`.
- `o_ide`, `o_rtr` and `o_dlc` are loaded as each field completes and hold until the next SOF.

## Timing
- Reset values:
  - `o_Data`=1, `o_frame_field`=0, `o_ide`=0, `o_rtr`=0, `o_dlc`=0.
  - All pulses 0.
  - Run counter 0; pending bit cleared.
- Latency: on the `i_bit_valid` of non-stuff bit n+1, the next clock updates `o_Data`/`o_frame_field` to bit n and pulses `o_bit_valid`. Outputs hold stable between updates.
- In IDLE, each recessive strobe updates the outputs with code 0 and data 1.
- No strobe means no state change.
- Reset mid-frame returns everything to reset values immediately; the next dominant strobe is SOF.
- `o_frame_done` is coincident with the `o_bit_valid` of the 7th EOF bit.
- `o_stuff_error` is coincident with the clock after the offending strobe.

## Test plan
- **Standard data frame**
  - Stimulus: ID 0x123, DLC 1, data 0xA5, correctly stuffed, ACK dominant.
  - Required: code sequence 1, 2×11, 3, 4, 6, 7×4, 12×8, 13×15, 17, 16, 18, 5×7, 15×3, then 0.
  - Required: `o_dlc`=1, one `o_frame_done`.
- **Extended frame**
  - Stimulus: ID 0x1ABCDEF0, DLC 0.
  - Required: bit 12 labelled 8, followed by 4, 9×18, 3, 11, 6, 7×4, 13×15.
  - Required: `o_ide`=1.
- **Stuffing**
  - Stimulus: base ID 0x000; stuff bits are inserted after each run of five 0s.
  - Required: no `o_bit_valid` on the stuff strobes and exactly 11 ID_BASE labels.
  - Stimulus: a stuff bit equal to the previous bit.
  - Required: an `o_stuff_error` pulse, then code 19 until 11 recessive bits, then 0.
- **Remote frame and oversized DLC**
  - Stimulus: remote frame, RTR=1, DLC 3.
  - Required: zero DATA bits.
  - Stimulus: data frame with DLC 12.
  - Required: 64 DATA bits and `o_dlc`=12.
- **Intermission**
  - Stimulus: dominant on intermission bit 3.
  - Required: next label is SOF(1).
  - Stimulus: dominant on intermission bit 1.
  - Required: ERROR(19).
- **Reset mid-frame**
  - Stimulus: assert `i_Reset` during DATA.
  - Required: outputs return to reset values at once; the following frame decodes correctly.
